fence_t_clr_seq: RTL and testbench

// - Sequences the fence.t microarchitectural reset after the flush controller has written back the dcache.
// - Phases: drain all units (handshake), pulse per-unit clear in index order, hold cache-init suppression, signal done.
// - Sits between the flush controller (start/done) and the per-unit clear inputs (frontend, issue, ex, caches).

---
 rtl/fence_t_clr_seq_pkg.sv | 23 ++
 rtl/fence_t_clr_seq_cnt.sv | 31 +++
 rtl/fence_t_clr_seq.sv | 165 ++++++++++++++++
 tb/tb_fence_t_clr_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fence_t_clr_seq_pkg.sv
// Shared types and defaults for the fence.t clear sequencer.
//   fence_t_seq_state_e : sequencer FSM state encoding
//   FENCE_T_CLR_CYCLES  : default cycles each per-unit clear is held
//   FENCE_T_INIT_CYCLES : default cycles cache init is suppressed
//   cnt_w()             : counter width for a given maximum, minimum 1 bit
package fence_t_clr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    CLEAR,
    INIT,
    DONE
  } fence_t_seq_state_e;

  localparam int unsigned FENCE_T_CLR_CYCLES  = 16;
  localparam int unsigned FENCE_T_INIT_CYCLES = 3;

  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/fence_t_clr_seq_cnt.sv
// Up-counter with synchronous clear and enable, used as the shared phase counter.
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   clr_i : synchronous clear to 0 (has priority over en_i)
//   en_i  : increment by one
//   q_o   : current count
module fence_t_clr_seq_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= q_q + WIDTH'(1);
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fence_t_clr_seq.sv
// fence.t microarchitectural reset sequencer: drain all units, pulse each unit's
// clear in index order, suppress cache init, then pulse done.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   start_i            : request a sequence (accepted in IDLE only)
//   busy_o             : high outside IDLE
//   unit_drain_req_o   : all ones during DRAIN
//   unit_idle_i        : per-unit idle handshake
//   unit_clr_o         : one-hot clear during CLEAR
//   cache_init_no_o    : high during INIT
//   done_o             : one-cycle pulse in DONE
//   timeout_o          : sticky, last DRAIN ended by timeout
//   last_dur_o         : DRAIN..DONE cycle count of the last sequence
// Optional: define FENCE_T_CLR_STATS_EN to build the duration counter;
// otherwise last_dur_o is tied to 0.
module fence_t_clr_seq
  import fence_t_clr_seq_pkg::*;
#(
  parameter int unsigned NR_UNITS    = 4,
  parameter int unsigned CLR_CYCLES  = FENCE_T_CLR_CYCLES,
  parameter int unsigned INIT_CYCLES = FENCE_T_INIT_CYCLES,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic [NR_UNITS-1:0] unit_drain_req_o,
  input  logic [NR_UNITS-1:0] unit_idle_i,
  output logic [NR_UNITS-1:0] unit_clr_o,
  output logic                cache_init_no_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic [31:0]         last_dur_o
);

  localparam int unsigned PhMax = (CLR_CYCLES > INIT_CYCLES) ? CLR_CYCLES : INIT_CYCLES;
  localparam int unsigned PhW   = cnt_w(PhMax);
  localparam int unsigned UnitW = cnt_w(NR_UNITS);

  localparam logic [PhW-1:0]   PhClrLast  = PhW'(CLR_CYCLES - 1);
  localparam logic [PhW-1:0]   PhInitLast = PhW'(INIT_CYCLES - 1);
  localparam logic [UnitW-1:0] UnitLast   = UnitW'(NR_UNITS - 1);
  localparam logic [TO_W-1:0]  ToLast     = TO_W'(TIMEOUT - 1);

  fence_t_seq_state_e state_q, state_d;
  logic [UnitW-1:0]   unit_q, unit_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               timeout_q, timeout_d;
  logic               ph_clr, ph_en;
  logic [PhW-1:0]     ph_q;

  fence_t_clr_seq_cnt #(
    .WIDTH (PhW)
  ) u_phase_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (ph_clr),
    .en_i  (ph_en),
    .q_o   (ph_q)
  );

  always_comb begin
    state_d   = state_q;
    unit_d    = unit_q;
    to_d      = to_q;
    timeout_d = timeout_q;
    ph_clr    = 1'b0;
    ph_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = DRAIN;
          to_d      = '0;
          timeout_d = 1'b0;
          unit_d    = '0;
          ph_clr    = 1'b1;
        end
      end
      DRAIN: begin
        // All idle bits must be seen high together; a later drop is irrelevant.
        if (&unit_idle_i) begin
          state_d = CLEAR;
        end else if (to_q == ToLast) begin
          state_d   = CLEAR;
          timeout_d = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      CLEAR: begin
        if (ph_q == PhClrLast) begin
          ph_clr = 1'b1;
          if (unit_q == UnitLast) begin
            state_d = INIT;
          end else begin
            unit_d = unit_q + UnitW'(1);
          end
        end else begin
          ph_en = 1'b1;
        end
      end
      INIT: begin
        if (ph_q == PhInitLast) begin
          ph_clr  = 1'b1;
          state_d = DONE;
        end else begin
          ph_en = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      unit_q    <= '0;
      to_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      unit_q    <= unit_d;
      to_q      <= to_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs decode registered state only, so reset clears them without a clock edge.
  assign busy_o           = (state_q != IDLE);
  assign unit_drain_req_o = (state_q == DRAIN) ? {NR_UNITS{1'b1}} : '0;
  assign unit_clr_o       = (state_q == CLEAR) ? (NR_UNITS'(1) << unit_q) : '0;
  assign cache_init_no_o  = (state_q == INIT);
  assign done_o           = (state_q == DONE);
  assign timeout_o        = timeout_q;

`ifdef FENCE_T_CLR_STATS_EN
  logic [31:0] dur_q, dur_inc, last_dur_q;

  assign dur_inc = (&dur_q) ? dur_q : dur_q + 32'd1;

  // dur_q counts busy cycles before the current one, so DONE adds one for itself.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dur_q      <= '0;
      last_dur_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        dur_q <= '0;
      end else begin
        dur_q <= dur_inc;
      end
      if (state_q == DONE) begin
        last_dur_q <= dur_inc;
      end
    end
  end

  assign last_dur_o = last_dur_q;
`else
  assign last_dur_o = '0;
`endif

endmodule

// File: tb/tb_fence_t_clr_seq.sv
module tb_fence_t_clr_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic [3:0]  drain_req;
  logic [3:0]  unit_idle;
  logic [3:0]  unit_clr;
  logic        init_no;
  logic        done;
  logic        tmo;
  logic [31:0] last_dur;

  int n_vec = 0;
  int n_err = 0;

`ifdef FENCE_T_CLR_STATS_EN
  localparam logic [31:0] ExpDur = 32'd69;
`else
  localparam logic [31:0] ExpDur = 32'd0;
`endif

  fence_t_clr_seq u_dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .busy_o           (busy),
    .unit_drain_req_o (drain_req),
    .unit_idle_i      (unit_idle),
    .unit_clr_o       (unit_clr),
    .cache_init_no_o  (init_no),
    .done_o           (done),
    .timeout_o        (tmo),
    .last_dur_o       (last_dur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {busy, drain_req, unit_clr, init, done}
  function automatic logic [31:0] obs();
    return {21'd0, busy, drain_req, unit_clr, init_no, done};
  endfunction

  // Expected outputs for cycle c of a run with all units idle, start at cycle 0.
  function automatic logic [31:0] exp_imm(input int c);
    logic       b, i, d;
    logic [3:0] dr, cl;
    b  = (c >= 1) && (c <= 69);
    dr = (c == 1) ? 4'hF : 4'h0;
    cl = ((c >= 2) && (c <= 65)) ? (4'b0001 << ((c - 2) / 16)) : 4'h0;
    i  = (c >= 66) && (c <= 68);
    d  = (c == 69);
    return {21'd0, b, dr, cl, i, d};
  endfunction

  task automatic wait_done(input int max_cyc);
    int k;
    k = 0;
    while (!done && k < max_cyc) begin
      step();
      k++;
    end
    if (!done) check("wait_done bound", 32'd0, 32'd1);
  endtask

  task automatic run_immediate(input string name);
    unit_idle = 4'hF;
    start     = 1'b1;
    check({name, " c0"}, obs(), 32'd0);
    for (int c = 1; c <= 70; c++) begin
      step();
      start = 1'b0;
      check($sformatf("%s c%0d", name, c), obs(), exp_imm(c));
    end
    check({name, " timeout"}, {31'd0, tmo}, 32'd0);
    check({name, " last_dur"}, last_dur, ExpDur);
  endtask

  initial begin
    int ndone;
    int done_cyc;
    rst       = 1'b1;
    start     = 1'b0;
    unit_idle = 4'h0;
    step();
    step();
    check("reset outputs", obs(), 32'd0);
    check("reset timeout", {31'd0, tmo}, 32'd0);
    check("reset last_dur", last_dur, 32'd0);
    rst = 1'b0;
    step();

    // Immediate idle.
    run_immediate("imm");

    // Staggered drain: bits rise at cycles 3,5,7,9.
    unit_idle = 4'h0;
    start     = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      start = 1'b0;
      if (c == 3) unit_idle[0] = 1'b1;
      if (c == 5) unit_idle[1] = 1'b1;
      if (c == 7) unit_idle[2] = 1'b1;
      if (c == 9) unit_idle[3] = 1'b1;
      if (c < 10) begin
        check($sformatf("stag drain c%0d", c), {24'd0, drain_req, unit_clr}, 32'hF0);
      end else begin
        check("stag clear c10", {24'd0, drain_req, unit_clr}, 32'h01);
      end
    end
    wait_done(100);
    step();

    // Timeout: unit 3 never idle.
    unit_idle = 4'b0111;
    start     = 1'b1;
    for (int c = 1; c <= 256; c++) begin
      step();
      start = 1'b0;
      if (c == 255) begin
        check("tmo c255 drain", {28'd0, drain_req}, 32'hF);
        check("tmo c255 flag", {31'd0, tmo}, 32'd0);
      end
      if (c == 256) begin
        check("tmo c256 clr", {24'd0, drain_req, unit_clr}, 32'h01);
        check("tmo c256 flag", {31'd0, tmo}, 32'd1);
      end
    end
    wait_done(200);
    step();
    step();
    check("tmo idle busy", {31'd0, busy}, 32'd0);
    check("tmo sticky", {31'd0, tmo}, 32'd1);

    // Next accepted start clears timeout; start pulses in CLEAR and DONE are ignored.
    unit_idle = 4'hF;
    start     = 1'b1;
    ndone     = 0;
    done_cyc  = -1;
    for (int c = 1; c <= 150; c++) begin
      step();
      start = (c == 10) || (c == 69);
      if (c == 1) check("restart tmo clr", {31'd0, tmo}, 32'd0);
      if (done) begin
        ndone++;
        done_cyc = c;
      end
      if (c == 70) check("busy drop c70", {31'd0, busy}, 32'd0);
    end
    check("ignore start ndone", ndone, 32'd1);
    check("ignore start done cyc", done_cyc, 32'd69);
    check("ignore start idle", obs(), 32'd0);

    // Async reset mid-CLEAR: unit 2 starts at cycle 34, phase 5 is cycle 39.
    unit_idle = 4'hF;
    start     = 1'b1;
    for (int c = 1; c <= 39; c++) begin
      step();
      start = 1'b0;
    end
    check("pre-reset clr u2", {28'd0, unit_clr}, 32'h4);
    #3;
    rst = 1'b1;
    #1;
    check("async reset outputs", obs(), 32'd0);
    check("async reset last_dur", last_dur, 32'd0);
    #2;
    rst = 1'b0;
    step();
    check("post-reset idle", obs(), 32'd0);
    run_immediate("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit: got no finish, expected finish");
    $fatal(1);
  end

endmodule
